// File: rtl/relu_fmap_streamer.sv
// ReLU/shift/clamp pixel writer with a one-frame buffer replayed in raster order.
// Define RELU_SAT_EN to saturate at 2^IF_BW-1; otherwise the low IF_BW bits wrap.
module relu_fmap_streamer #(
  parameter int CI         = 3,
  parameter int IF_BW      = 8,
  parameter int CONV_BW    = 20,
  parameter int FM_X       = 6,
  parameter int FM_Y       = 6,
  parameter int SHIFT      = 4,
  parameter int STREAM_GAP = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_in_valid,
  input  logic [CI*CONV_BW-1:0] i_in_conv,
  output logic                  o_in_ready,
  output logic                  o_Relu_valid,
  output logic [CI*IF_BW-1:0]   o_in_Relu,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int N  = FM_X * FM_Y;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (STREAM_GAP > 0) ? $clog2(STREAM_GAP + 1) : 1;
  localparam int DW = CI * IF_BW;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
`ifdef RELU_SAT_EN
  localparam logic signed [CONV_BW-1:0] YMAX = CONV_BW'((1 << IF_BW) - 1);
`endif

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [DW-1:0]     data_q;
  logic              wr_en, rd_en;
  logic [DW-1:0]     relu_w;
  logic signed [CONV_BW-1:0] x_w, y_w;
  logic [IF_BW-1:0]  ch_w;

  logic [DW-1:0] mem [N];

  always_comb begin
    relu_w = '0;
    x_w    = '0;
    y_w    = '0;
    ch_w   = '0;
    for (int c = 0; c < CI; c++) begin
      x_w = $signed(i_in_conv[c*CONV_BW +: CONV_BW]);
      y_w = x_w >>> SHIFT;
      if (x_w[CONV_BW-1]) begin
        ch_w = '0;
`ifdef RELU_SAT_EN
      end else if (y_w > YMAX) begin
        ch_w = '1;
`endif
      end else begin
        ch_w = y_w[IF_BW-1:0];
      end
      relu_w[c*IF_BW +: IF_BW] = ch_w;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    gap_d      = '0;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    o_in_ready = 1'b0;
    o_busy     = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    unique case (state_q)
      LOAD: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          wr_en = 1'b1;
          if (wr_ptr_q == LAST) begin
            wr_ptr_d = '0;
            state_d  = STREAM;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      STREAM: begin
        o_busy = 1'b1;
        // one read per (STREAM_GAP+1) cycles
        if (gap_q == '0) begin
          rd_en   = 1'b1;
          valid_d = 1'b1;
          gap_d   = GW'(STREAM_GAP);
          if (rd_ptr_q == LAST) begin
            rd_ptr_d = '0;
            state_d  = DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      DONE: begin
        o_busy  = 1'b1;
        done_d  = 1'b1;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      gap_q    <= gap_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= relu_w;
    end
  end

  // Holds the last beat while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (rd_en) begin
      data_q <= mem[rd_ptr_q];
    end
  end

  assign o_Relu_valid = valid_q;
  assign o_in_Relu    = data_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_relu_fmap_streamer.sv
// Bench for relu_fmap_streamer: random and directed frames vs a ReLU model.
// Covers RELU_SAT_EN on or off, and a second instance with STREAM_GAP = 2.
module tb_relu_fmap_streamer;

  localparam int CI = 3;
  localparam int IF_BW = 8;
  localparam int CONV_BW = 20;
  localparam int N = 36;
  localparam int SHIFT = 4;
  localparam int DW = CI * IF_BW;
  localparam int IW = CI * CONV_BW;
`ifdef RELU_SAT_EN
  localparam logic [DW-1:0] SPECIAL = 24'hFF0000;
`else
  localparam logic [DW-1:0] SPECIAL = 24'h000000;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic i_in_valid;
  logic [IW-1:0] i_in_conv;
  logic sel;
  logic v0, v1;
  logic rdy0, val0, busy0, fd0;
  logic rdy1, val1, busy1, fd1;
  logic [DW-1:0] dat0, dat1;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit mon_on;

  logic [IW-1:0] in_q[$];
  logic [IW-1:0] sent_q[$];
  int acc_q[$];
  logic [DW-1:0] oq[$];
  int ocyc[$];
  int done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v0 = i_in_valid & ~sel;
  assign v1 = i_in_valid & sel;

  relu_fmap_streamer #(.STREAM_GAP(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_in_valid(v0), .i_in_conv(i_in_conv),
    .o_in_ready(rdy0), .o_Relu_valid(val0),
    .o_in_Relu(dat0), .o_busy(busy0),
    .o_frame_done(fd0)
  );

  relu_fmap_streamer #(.STREAM_GAP(2)) dut_g (
    .clk(clk), .reset_n(reset_n),
    .i_in_valid(v1), .i_in_conv(i_in_conv),
    .o_in_ready(rdy1), .o_Relu_valid(val1),
    .o_in_Relu(dat1), .o_busy(busy1),
    .o_frame_done(fd1)
  );

  always @(negedge clk) begin
    if (mon_on) begin
      if (sel ? val1 : val0) begin
        oq.push_back(sel ? dat1 : dat0);
        ocyc.push_back(cyc);
      end
      if (sel ? fd1 : fd0) done_q.push_back(cyc);
    end
  end

  function automatic logic [IF_BW-1:0] relu_ref(input int x);
    int y;
    if (x < 0) return '0;
    y = x / (1 << SHIFT);
`ifdef RELU_SAT_EN
    if (y > 255) return 8'hFF;
`endif
    return 8'(y % 256);
  endfunction

  function automatic logic [DW-1:0] exp_pix(input logic [IW-1:0] p);
    logic [DW-1:0] r;
    logic [CONV_BW-1:0] f;
    r = '0;
    for (int c = 0; c < CI; c++) begin
      f = p[c*CONV_BW +: CONV_BW];
      r[c*IF_BW +: IF_BW] = relu_ref(int'($signed(f)));
    end
    return r;
  endfunction

  function automatic logic [CONV_BW-1:0] rnd_ch();
    int v;
    case ($urandom_range(0, 3))
      0: v = -int'($urandom_range(1, 1 << 19));
      1: v = int'($urandom_range(0, 4095));
      2: v = int'($urandom_range(0, (1 << 19) - 1));
      default: v = int'($urandom_range(4000, 4200));
    endcase
    return CONV_BW'(v);
  endfunction

  function automatic logic rdy();
    return sel ? rdy1 : rdy0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    oq.delete();
    ocyc.delete();
    done_q.delete();
    sent_q.delete();
    acc_q.delete();
  endtask

  // kind 0: all 80, 1: raster ch0 = 16*i, 2: special pixel 0, 3: random
  task automatic gen_frame(input int kind);
    logic [IW-1:0] p;
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < CI; c++) p[c*CONV_BW +: CONV_BW] = rnd_ch();
      if (kind == 0) p = {CI{20'd80}};
      if (kind == 1) p[CONV_BW-1:0] = CONV_BW'(16 * i);
      if (kind == 2 && i == 0) p = {20'd65536, 20'd0, -20'sd32};
      in_q.push_back(p);
    end
  endtask

  task automatic drive(input int cnt, input bit junk);
    int got = 0;
    int budget = 0;
    logic [IW-1:0] cur;
    while (got < cnt && budget < 3000) begin
      @(posedge clk);
      #1;
      budget++;
      if (rdy()) begin
        cur = in_q[0];
        i_in_valid = 1'b1;
        i_in_conv = cur;
      end else begin
        i_in_valid = junk;
        i_in_conv = {CI{20'h7FFFF}};
      end
      @(negedge clk);
      if (rdy() && i_in_valid) begin
        void'(in_q.pop_front());
        sent_q.push_back(cur);
        acc_q.push_back(cyc);
        got++;
      end
    end
    if (got < cnt) chk("drive_timeout", 64'(got), 64'(cnt));
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic check_frames(input int nf, input int g);
    int b = 0;
    int k, idx;
    while (done_q.size() < nf && b < 3000) begin
      @(negedge clk);
      b++;
    end
    repeat (4) @(negedge clk);
    chk("beat_count", 64'(oq.size()), 64'(nf * N));
    chk("done_count", 64'(done_q.size()), 64'(nf));
    for (int f = 0; f < nf; f++) begin
      if (f * N + N - 1 < acc_q.size()) begin
        k = acc_q[f*N+N-1];
        for (int i = 0; i < N; i++) begin
          idx = f * N + i;
          if (idx < oq.size()) begin
            chk($sformatf("beat_data f%0d i%0d", f, i), 64'(oq[idx]),
                64'(exp_pix(sent_q[idx])));
            chk($sformatf("beat_cycle f%0d i%0d", f, i), 64'(ocyc[idx]),
                64'(k + 2 + (g + 1) * i));
          end
        end
        if (f < done_q.size())
          chk($sformatf("done_cycle f%0d", f), 64'(done_q[f]),
              64'(k + 2 + (g + 1) * (N - 1) + 1));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset_n = 1'b0;
    i_in_valid = 1'b0;
    i_in_conv = '0;
    sel = 1'b0;
    mon_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(val0), 64'(0));
    chk("rst_data", 64'(dat0), 64'(0));
    chk("rst_busy", 64'(busy0), 64'(0));
    chk("rst_done", 64'(fd0), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 64'(rdy0), 64'(1));

    // Frame A: all channels 80 -> 5
    clear_q();
    gen_frame(0);
    drive(N, 1'b0);
    chk("a_ready_low", 64'(rdy0), 64'(0));
    chk("a_busy_high", 64'(busy0), 64'(1));
    check_frames(1, 0);
    if (oq.size() > 0) chk("a_pix0", 64'(oq[0]), 64'(24'h050505));
    chk("a_idle_ready", 64'(rdy0), 64'(1));
    chk("a_idle_busy", 64'(busy0), 64'(0));

    // Frames B+C back to back, junk valid held high during B stream
    clear_q();
    gen_frame(1);
    gen_frame(2);
    drive(2 * N, 1'b1);
    check_frames(2, 0);
    for (int i = 0; i < N; i++)
      if (i < oq.size())
        chk($sformatf("raster%0d", i), 64'(oq[i][7:0]), 64'(i));
    if (acc_q.size() > N && done_q.size() > 0)
      chk("done_accept", 64'(acc_q[N]), 64'(done_q[0]));
    if (oq.size() > N) chk("special", 64'(oq[N]), 64'(SPECIAL));

    // Frame D interrupted by reset at stream beat 10
    clear_q();
    gen_frame(3);
    drive(N, 1'b0);
    b = 0;
    while (oq.size() < 10 && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("d_reached_beat10", 64'(oq.size() >= 10), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(val0), 64'(0));
    chk("mid_rst_data", 64'(dat0), 64'(0));
    chk("mid_rst_busy", 64'(busy0), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(rdy0), 64'(1));
    chk("post_rst_busy", 64'(busy0), 64'(0));
    chk("post_rst_valid", 64'(val0), 64'(0));

    // Frame E: fresh frame after reset
    clear_q();
    gen_frame(3);
    drive(N, 1'b0);
    check_frames(1, 0);

    // Frame F on the STREAM_GAP = 2 instance
    sel = 1'b1;
    clear_q();
    gen_frame(3);
    drive(N, 1'b1);
    check_frames(1, 2);
    chk("g_idle_ready", 64'(rdy1), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/relu_fmap_streamer.md
Name: relu_fmap_streamer

Overview:
- Transmit side of the ReLU feature-map stream consumed by the CNN pooling/accumulate/core chain.
- Accepts signed convolution results one pixel per beat (all CI channels in parallel), applies ReLU, scaling and clamping, and buffers one full FM_X×FM_Y frame.
- Replays the frame in raster order as a valid-qualified stream: o_Relu_valid with o_in_Relu, CI×IF_BW bits per beat.
- Double-direction partner of the pooling input: it produces exactly the beat format and order that interface receives.

Parameters:
- CI, 3, channels per pixel; matches `CI in defines_cnn_core.vh.
- IF_BW, 8, unsigned ReLU output width per channel; matches `IF_BW.
- CONV_BW, 20, signed conv input width per channel.
- FM_X, 6, frame width in pixels.
- FM_Y, 6, frame height in pixels.
- SHIFT, 4, arithmetic right shift applied before clamp.
- STREAM_GAP, 0, idle cycles inserted between output beats.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i_in_valid  in  1  conv pixel valid
- i_in_conv  in  CI*CONV_BW  signed conv results; channel c at bits [c*CONV_BW +: CONV_BW]
- o_in_ready  out  1  buffer accepting pixels
- o_Relu_valid  out  1  output beat valid
- o_in_Relu  out  CI*IF_BW  ReLU pixel; channel c at bits [c*IF_BW +: IF_BW]
- o_busy  out  1  high while streaming
- o_frame_done  out  1  one-cycle pulse after last beat of a frame

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - Asynchronous active-low reset on reset_n.
- Reset values:
  - State LOAD.
  - wr_ptr = 0, rd_ptr = 0, gap counter = 0.
  - o_Relu_valid = 0, o_in_Relu = 0, o_busy = 0, o_frame_done = 0.
  - o_in_ready = 1 after reset release.
- Storage: N = FM_X*FM_Y entries × CI*IF_BW bits, synchronous-read memory (inferable as BRAM/LUTRAM).
- ReLU per channel, combinational on the write path:
  - x < 0 → 0.
  - Otherwise y = x >>> SHIFT, then clamp per Optional Feature.
- State machine has three states: LOAD, STREAM, DONE.
- LOAD:
  - o_in_ready = 1.
  - Each i_in_valid & o_in_ready writes ReLU(i_in_conv) to mem[wr_ptr], then wr_ptr++.
  - On the accept where wr_ptr == N-1: wr_ptr ← 0, next state STREAM.
  - o_in_ready = 0 from the following cycle.
- STREAM:
  - o_in_ready = 0; i_in_valid is ignored and nothing is written.
  - o_busy = 1.
  - Read address rd_ptr is issued every (STREAM_GAP+1) cycles.
  - Data plus o_Relu_valid appear one cycle after the address is issued.
  - After the address for N-1 is issued: rd_ptr ← 0, next state DONE.
- DONE (one cycle):
  - Last beat is on the output this cycle.
  - Next cycle: o_frame_done = 1, state LOAD, o_in_ready = 1, o_busy = 0.
- Latency with STREAM_GAP = 0:
  - Last accept at cycle k.
  - Pixel i is valid at cycle k+2+i.
  - o_Relu_valid is high for exactly N consecutive cycles.
  - o_frame_done at k+N+2.
  - The first new pixel can be accepted at k+N+2.
- Latency with STREAM_GAP = G: beats are spaced G+1 cycles apart; o_Relu_valid is high one cycle per beat.
- o_in_Relu holds its last value when o_Relu_valid = 0; the consumer must qualify with valid.
- Simultaneous frame_done and a new i_in_valid in the same cycle: the input is accepted (ready = 1) into entry 0.
- Reset asserted mid-LOAD or mid-STREAM:
  - Outputs clear immediately (asynchronous).
  - Partial frame is discarded.
  - Memory contents are don't-care, since they are never read before being rewritten.
- Arithmetic:
  - Shift is signed, with sign extension.
  - Clamp comparison is done at CONV_BW width.
  - No rounding; bits are truncated.

Optional Feature:
- Macro: RELU_SAT_EN.
- Defined: y > 2^IF_BW-1 saturates to 2^IF_BW-1 (255 at defaults).
- Undefined: output is the low IF_BW bits of y (wrap). Smaller logic, valid only when the conv range is known to fit.

Test Plan:
- Reset, then 36 beats with all channels = 80 (SHIFT 4) → o_in_ready drops after beat 36; 36 consecutive o_Relu_valid with each channel = 5, starting 2 cycles after the last accept; o_frame_done one cycle after the last valid.
- Channel values {-32, 0, 65536} → outputs {0, 0, 255} with RELU_SAT_EN; {0, 0, 0} without it (4096 wraps to 0).
- Raster order: pixel i has channel 0 = 16*i → stream channel 0 reads 0, 1, 2, …, 35 in order; no gaps, no duplicates.
- i_in_valid held high through STREAM with value 0x7FFFF → no writes; the next frame holds only newly supplied data; frame-done cycle accepts the first new pixel.
- Assert reset_n low at stream beat 10 → o_Relu_valid = 0 immediately; after release o_in_ready = 1, o_busy = 0, and a fresh 36-beat frame streams correctly.
- STREAM_GAP = 2 → valid beats every 3rd cycle, 36 beats total, o_frame_done one cycle after the last beat.
